// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared encodings for the unified memory port arbiter and its lane
//   formatter. This package has no ports.
//   - Access size codes used on d_size and by mem_lane_fmt.
//   - Arbiter FSM state codes.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   // Access sizes. Code 3 is not a legal size and is handled as a word.
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Arbiter FSM states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_BUSY_I = 2'd1;
   localparam logic [1:0] ST_BUSY_D = 2'd2;

endpackage

// File: rtl/mem_lane_fmt.sv
// -----------------------------------------------------------------------------
// mem_lane_fmt
//   Purely combinational formatter. It turns an access size, the low address
//   bits and right-aligned write data into byte enables, lane-replicated write
//   data and a misalignment flag. The memory model can reuse it.
// Ports:
//   i_size     access size (SZ_B / SZ_H / SZ_W; 3 is treated as word)
//   i_addr_lo  byte address bits [1:0]
//   i_wdata    right-aligned write data
//   o_be       byte enables
//   o_wdata    write data replicated across the lanes
//   o_misalign access is not naturally aligned
// -----------------------------------------------------------------------------
module mem_lane_fmt
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic        o_misalign
);

   always_comb begin
      o_be       = 4'b1111;
      o_wdata    = i_wdata;
      o_misalign = 1'b0;
      case (i_size)
         SZ_B: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
         end
         SZ_H: begin
            // For odd addresses the shifted enables are meaningless. The
            // access is flagged misaligned and never reaches memory.
            o_be       = 4'b0011 << i_addr_lo;
            o_wdata    = {2{i_wdata[15:0]}};
            o_misalign = i_addr_lo[0];
         end
         default: begin
            o_misalign = |i_addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported unified memory between the fetch (I) port and
//   the load/store (D) port. Each granted access becomes one memory
//   transaction. Byte enables and lane-replicated write data come from the
//   access size. Misaligned accesses are rejected without touching memory.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   i_req/i_addr             fetch request, held until i_done
//   i_done/i_err/i_rdata     fetch completion pulse, misalign flag, read word
//   i_stall                  i_req & ~i_done
//   d_req/d_we/d_size/d_addr/d_wdata  load/store request, held until d_done
//   d_done/d_err/d_rdata     data completion pulse, misalign flag, raw read word
//   d_stall                  d_req & ~d_done
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata  memory transaction (registered)
//   mem_rdata/mem_ack        memory read data and completion
//
// Handshake: a requester raises x_req and holds it and its address/data
// stable until x_done pulses for one cycle. On the memory side mem_req stays
// high with constant mem_we/addr/be/wdata until a cycle where mem_ack is
// high; that cycle completes the transaction. mem_ack may come in the first
// mem_req cycle or later. An ack seen while idle is ignored.
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW           = 32,
   parameter int MAX_D_STREAK = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_done,
   output logic          i_err,
   output logic [31:0]   i_rdata,
   output logic          i_stall,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [1:0]    d_size,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_done,
   output logic          d_err,
   output logic [31:0]   d_rdata,
   output logic          d_stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [3:0]    mem_be,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_ack
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

   logic [1:0]    r_state;
   logic [3:0]    r_streak;
   logic          r_i_done, r_i_err, r_d_done, r_d_err;
   logic [31:0]   r_i_rdata, r_d_rdata;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [3:0]    r_mem_be;
   logic [31:0]   r_mem_wdata;

   logic          w_arb_ok, w_d_win, w_i_win;
   logic [1:0]    w_fmt_size, w_fmt_lo;
   logic [31:0]   w_fmt_wdata;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic          w_misalign;

   // Arbitration is held off while a done pulse is out. This gives the
   // requester one cycle to drop or change its request before the next
   // grant.
   assign w_arb_ok = (r_state == ST_IDLE) & ~r_i_done & ~r_d_done;
   assign w_d_win  = w_arb_ok & d_req & ~(i_req & (r_streak == STREAK_MAX));
   assign w_i_win  = w_arb_ok & i_req & ~w_d_win;

   // One formatter serves both ports. A fetch is always a word read.
   assign w_fmt_size  = w_d_win ? d_size       : SZ_W;
   assign w_fmt_lo    = w_d_win ? d_addr[1:0]  : i_addr[1:0];
   assign w_fmt_wdata = w_d_win ? d_wdata      : 32'd0;

   mem_lane_fmt u_lane_fmt (
      .i_size     (w_fmt_size),
      .i_addr_lo  (w_fmt_lo),
      .i_wdata    (w_fmt_wdata),
      .o_be       (w_be),
      .o_wdata    (w_wdata),
      .o_misalign (w_misalign)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_i_done    <= 1'b0;
         r_i_err     <= 1'b0;
         r_d_done    <= 1'b0;
         r_d_err     <= 1'b0;
         r_i_rdata   <= 32'd0;
         r_d_rdata   <= 32'd0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= 4'd0;
         r_mem_wdata <= 32'd0;
      end else begin
         r_i_done <= 1'b0;
         r_i_err  <= 1'b0;
         r_d_done <= 1'b0;
         r_d_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_d_win) begin
                  if (w_misalign) begin
                     r_d_done  <= 1'b1;
                     r_d_err   <= 1'b1;
                     r_d_rdata <= 32'd0;
                  end else begin
                     r_state     <= ST_BUSY_D;
                     r_mem_we    <= d_we;
                     r_mem_addr  <= {d_addr[AW-1:2], 2'b00};
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_wdata;
                  end
               end else if (w_i_win) begin
                  if (w_misalign) begin
                     r_i_done  <= 1'b1;
                     r_i_err   <= 1'b1;
                     r_i_rdata <= 32'd0;
                  end else begin
                     r_state     <= ST_BUSY_I;
                     r_mem_we    <= 1'b0;
                     r_mem_addr  <= {i_addr[AW-1:2], 2'b00};
                     r_mem_be    <= w_be;
                     r_mem_wdata <= 32'd0;
                  end
               end
            end
            ST_BUSY_I: begin
               if (mem_ack) begin
                  r_i_rdata <= mem_rdata;
                  r_i_done  <= 1'b1;
                  r_mem_we  <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            ST_BUSY_D: begin
               if (mem_ack) begin
                  // Stores return a zero word, not whatever is on the read bus.
                  r_d_rdata <= r_mem_we ? 32'd0 : mem_rdata;
                  r_d_done  <= 1'b1;
                  r_mem_we  <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // The streak counts D grants that I has been kept waiting through. It
   // saturates at the limit, and at the limit the next grant goes to I.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_streak <= 4'd0;
      end else if (!i_req || w_i_win) begin
         r_streak <= 4'd0;
      end else if (w_d_win && (r_streak != STREAK_MAX)) begin
         r_streak <= r_streak + 4'd1;
      end
   end

   assign mem_req   = (r_state != ST_IDLE);
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;
   assign i_done    = r_i_done;
   assign i_err     = r_i_err;
   assign i_rdata   = r_i_rdata;
   assign d_done    = r_d_done;
   assign d_err     = r_d_err;
   assign d_rdata   = r_d_rdata;
   assign i_stall   = i_req & ~r_i_done;
   assign d_stall   = d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small wait-state memory model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done, i_err, i_stall;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_done, d_err, d_stall;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // memory model: ack after wait_cfg wait cycles, plus a forced stray ack
  int   wcnt = 0;
  int   wait_cfg;
  logic force_ack;
  logic [31:0] rd_word;

  assign mem_ack   = (mem_req && (wcnt == wait_cfg)) || force_ack;
  assign mem_rdata = rd_word;

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_err(i_err),
    .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_set(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic prev;
    rst = 1'b1; i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_size = SZ_W; d_addr = 32'd0; d_wdata = 32'd0;
    wait_cfg = 0; force_ack = 1'b0; rd_word = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_dones", {30'd0, i_done, d_done}, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // single fetch, zero-wait memory
    i_req = 1'b1; i_addr = 32'h10; rd_word = 32'h00500093;
    tick();
    check("f_mem_req", {31'd0, mem_req}, 32'd1);
    check("f_mem_addr", mem_addr, 32'h10);
    check("f_mem_be", {28'd0, mem_be}, 32'hF);
    check("f_mem_we", {31'd0, mem_we}, 32'd0);
    check("f_stall", {31'd0, i_stall}, 32'd1);
    tick();
    check("f_done", {31'd0, i_done}, 32'd1);
    check("f_err", {31'd0, i_err}, 32'd0);
    check("f_rdata", i_rdata, 32'h00500093);
    check("f_stall_done", {31'd0, i_stall}, 32'd0);
    i_req = 1'b0;
    tick();
    check("f_done_pulse", {31'd0, i_done}, 32'd0);

    // simultaneous I and D: D first, I granted in the third cycle
    i_req = 1'b1; i_addr = 32'h20;
    d_set(1'b0, SZ_W, 32'h100, 32'd0);
    rd_word = 32'hCAFEF00D;
    tick();
    check("sim_d_addr", mem_addr, 32'h100);
    check("sim_d_stall", {31'd0, d_stall}, 32'd1);
    tick();
    check("sim_d_done", {31'd0, d_done}, 32'd1);
    check("sim_d_rdata", d_rdata, 32'hCAFEF00D);
    d_req = 1'b0; rd_word = 32'h11112222;
    tick();
    check("sim_gap", {31'd0, mem_req}, 32'd0);
    tick();
    check("sim_i_req", {31'd0, mem_req}, 32'd1);
    check("sim_i_addr", mem_addr, 32'h20);
    tick();
    check("sim_i_done", {31'd0, i_done}, 32'd1);
    check("sim_i_rdata", i_rdata, 32'h11112222);
    i_req = 1'b0;
    tick();

    // starvation limit: four D grants, then I, then D again
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h300);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h300);
    i_req = 1'b1; i_addr = 32'h40;
    d_set(1'b0, SZ_W, 32'h300, 32'd0);
    rd_word = 32'h5A5A0001;
    n = 0;
    prev = mem_req;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (mem_req && !prev) begin
        n++;
        if (exp_q.size() > 0) check("grant_order", mem_addr, exp_q.pop_front());
      end
      prev = mem_req;
      if (i_done) i_req = 1'b0;
      if (d_done && n >= 6) d_req = 1'b0;
    end
    check("grant_count", n, 32'd6);
    check("starve_idle", {31'd0, mem_req}, 32'd0);

    // misaligned D word: no memory access, done+err next cycle, rdata 0
    d_set(1'b0, SZ_W, 32'h102, 32'd0);
    tick();
    check("mis_d_mem_req", {31'd0, mem_req}, 32'd0);
    check("mis_d_done", {31'd0, d_done}, 32'd1);
    check("mis_d_err", {31'd0, d_err}, 32'd1);
    check("mis_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    tick();
    check("mis_d_pulse", {30'd0, d_done, d_err}, 32'd0);

    // misaligned fetch
    i_req = 1'b1; i_addr = 32'h6;
    tick();
    check("mis_i_mem_req", {31'd0, mem_req}, 32'd0);
    check("mis_i_done_err", {30'd0, i_done, i_err}, 32'd3);
    check("mis_i_rdata", i_rdata, 32'd0);
    i_req = 1'b0;
    tick();

    // store byte 0xAB at 0x203
    d_set(1'b1, SZ_B, 32'h203, 32'h000000AB);
    rd_word = 32'hFFFFFFFF;
    tick();
    check("sb_addr", mem_addr, 32'h200);
    check("sb_be", {28'd0, mem_be}, 32'h8);
    check("sb_wdata", mem_wdata, 32'hABABABAB);
    check("sb_we", {31'd0, mem_we}, 32'd1);
    tick();
    check("sb_done", {30'd0, d_done, d_err}, 32'd2);
    check("sb_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    tick();

    // store half 0x1234 at 0x202
    d_set(1'b1, SZ_H, 32'h202, 32'h00001234);
    tick();
    check("sh_addr", mem_addr, 32'h200);
    check("sh_be", {28'd0, mem_be}, 32'hC);
    check("sh_wdata", mem_wdata, 32'h12341234);
    check("sh_we", {31'd0, mem_we}, 32'd1);
    tick();
    check("sh_done", {31'd0, d_done}, 32'd1);
    d_req = 1'b0;
    tick();

    // reset during BUSY_D with a 3-wait-state memory
    wait_cfg = 3; rd_word = 32'h77778888;
    d_set(1'b0, SZ_W, 32'h400, 32'd0);
    tick();
    check("rb_busy", {31'd0, mem_req}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    check("rb_async_req", {31'd0, mem_req}, 32'd0);
    check("rb_async_addr", mem_addr, 32'd0);
    #1;
    rst = 1'b0;
    d_req = 1'b0;
    force_ack = 1'b1;
    tick();
    check("rb_late_ack_done", {31'd0, d_done}, 32'd0);
    tick();
    check("rb_late_ack_req", {31'd0, mem_req}, 32'd0);
    check("rb_late_ack_done2", {31'd0, d_done}, 32'd0);
    force_ack = 1'b0;
    wait_cfg = 0; rd_word = 32'h0BADBEEF;
    tick();
    d_set(1'b0, SZ_W, 32'h404, 32'd0);
    tick();
    check("rb_fresh_addr", mem_addr, 32'h404);
    check("rb_fresh_req", {31'd0, mem_req}, 32'd1);
    tick();
    check("rb_fresh_done", {31'd0, d_done}, 32'd1);
    check("rb_fresh_rdata", d_rdata, 32'h0BADBEEF);
    d_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
